pulse_meter: RTL and testbench

Receive-side counterpart to the clock/pulse generators: measures a pulse train arriving on a single input, sampled on the system clock. Per pulse it reports high width and rising-edge-to-rising-edge period in clock cycles. It groups pulses into bursts separated by a low timeout and reports the pulse count per burst. Sits between a pulse source and downstream checking/display logic.

---
 rtl/pulse_meter_if.sv | 35 +++
 rtl/pulse_meter.sv | 181 ++++++++++++++++++
 tb/tb_pulse_meter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// rtl/pulse_meter_if.sv - pulse train input and per-pulse/per-burst measurement bundle
interface pulse_meter_if #(
    parameter int WIDTH = 8
);
    logic             signal;
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] period;
    logic             pulse_valid;
    logic             period_valid;
    logic [WIDTH-1:0] burst_count;
    logic             burst_done;
    logic             overflow;

    modport master (
        output signal,
        input  high_len,
        input  period,
        input  pulse_valid,
        input  period_valid,
        input  burst_count,
        input  burst_done,
        input  overflow
    );

    modport slave (
        input  signal,
        output high_len,
        output period,
        output pulse_valid,
        output period_valid,
        output burst_count,
        output burst_done,
        output overflow
    );
endinterface

// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - measures high width, rise-to-rise period and burst pulse count of an async pulse train
module pulse_meter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    pulse_meter_if.slave pm
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] LOW_LAST = WIDTH'(TIMEOUT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             s_prev_q;

    logic [1:0]       state_q,        state_d;
    logic [WIDTH-1:0] high_cnt_q,     high_cnt_d;
    logic [WIDTH-1:0] low_cnt_q,      low_cnt_d;
    logic [WIDTH-1:0] pulse_cnt_q,    pulse_cnt_d;
    logic [WIDTH-1:0] period_cnt_q,   period_cnt_d;
    logic [WIDTH-1:0] period_lat_q,   period_lat_d;
    logic             first_q,        first_d;

    logic [WIDTH-1:0] high_len_q,     high_len_d;
    logic [WIDTH-1:0] period_q,       period_d;
    logic             pulse_valid_q,  pulse_valid_d;
    logic             period_valid_q, period_valid_d;
    logic [WIDTH-1:0] burst_count_q,  burst_count_d;
    logic             burst_done_q,   burst_done_d;
    logic             overflow_q,     overflow_d;

    logic s;
    logic rise;
    logic fall;

    assign s    = sync2_q;
    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d        = state_q;
        high_cnt_d     = high_cnt_q;
        low_cnt_d      = low_cnt_q;
        pulse_cnt_d    = pulse_cnt_q;
        period_cnt_d   = period_cnt_q;
        period_lat_d   = period_lat_q;
        first_d        = first_q;
        high_len_d     = high_len_q;
        period_d       = period_q;
        pulse_valid_d  = 1'b0;
        period_valid_d = 1'b0;
        burst_count_d  = burst_count_q;
        burst_done_d   = 1'b0;
        overflow_d     = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_HIGH;
                    overflow_d   = 1'b0;
                    pulse_cnt_d  = CNT_ONE;
                    high_cnt_d   = CNT_ONE;
                    period_cnt_d = CNT_ONE;
                    first_d      = 1'b1;
                end
            end

            ST_HIGH: begin
                period_cnt_d = sat_inc(period_cnt_q);
                if (period_cnt_q == CNT_MAX) begin
                    overflow_d = 1'b1;
                end
                if (fall) begin
                    state_d       = ST_LOW;
                    high_len_d    = high_cnt_q;
                    pulse_valid_d = 1'b1;
                    low_cnt_d     = CNT_ONE;
                    first_d       = 1'b0;
                    // The first pulse of a burst has no preceding rise to measure from.
                    if (!first_q) begin
                        period_d       = period_lat_q;
                        period_valid_d = 1'b1;
                    end
                end else begin
                    high_cnt_d = sat_inc(high_cnt_q);
                    if (high_cnt_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end
                end
            end

            ST_LOW: begin
                // A rise on the cycle the gap would expire keeps the burst alive.
                if (rise) begin
                    state_d      = ST_HIGH;
                    high_cnt_d   = CNT_ONE;
                    period_lat_d = period_cnt_q;
                    period_cnt_d = CNT_ONE;
                    pulse_cnt_d  = sat_inc(pulse_cnt_q);
                    if (pulse_cnt_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    period_cnt_d = sat_inc(period_cnt_q);
                    if (period_cnt_q == CNT_MAX) begin
                        overflow_d = 1'b1;
                    end
                    if (low_cnt_q == LOW_LAST) begin
                        state_d       = ST_IDLE;
                        burst_count_d = pulse_cnt_q;
                        burst_done_d  = 1'b1;
                    end else begin
                        low_cnt_d = low_cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            s_prev_q       <= 1'b0;
            state_q        <= ST_IDLE;
            high_cnt_q     <= '0;
            low_cnt_q      <= '0;
            pulse_cnt_q    <= '0;
            period_cnt_q   <= '0;
            period_lat_q   <= '0;
            first_q        <= 1'b0;
            high_len_q     <= '0;
            period_q       <= '0;
            pulse_valid_q  <= 1'b0;
            period_valid_q <= 1'b0;
            burst_count_q  <= '0;
            burst_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            sync1_q        <= pm.signal;
            sync2_q        <= sync1_q;
            s_prev_q       <= sync2_q;
            state_q        <= state_d;
            high_cnt_q     <= high_cnt_d;
            low_cnt_q      <= low_cnt_d;
            pulse_cnt_q    <= pulse_cnt_d;
            period_cnt_q   <= period_cnt_d;
            period_lat_q   <= period_lat_d;
            first_q        <= first_d;
            high_len_q     <= high_len_d;
            period_q       <= period_d;
            pulse_valid_q  <= pulse_valid_d;
            period_valid_q <= period_valid_d;
            burst_count_q  <= burst_count_d;
            burst_done_q   <= burst_done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign pm.high_len     = high_len_q;
    assign pm.period       = period_q;
    assign pm.pulse_valid  = pulse_valid_q;
    assign pm.period_valid = period_valid_q;
    assign pm.burst_count  = burst_count_q;
    assign pm.burst_done   = burst_done_q;
    assign pm.overflow     = overflow_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb/tb_pulse_meter.sv - scoreboard bench for pulse_meter with directed pulse trains
module tb_pulse_meter;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pulse_meter_if #(.WIDTH(WIDTH)) pm ();

    pulse_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .pm    (pm)
    );

    always #12 clock = ~clock;

    typedef struct {
        int hl;
        bit pv;
        int per;
    } pulse_exp_t;

    pulse_exp_t pq[$];
    int         bq[$];
    pulse_exp_t e;
    int         b;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int last_pv_cyc = 0;
    bit async_mode  = 1'b0;
    int async_pv    = 0;
    int model_rises = 0;
    logic m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_pulse(input int hl, input bit pv, input int per);
        pulse_exp_t x;
        x.hl  = hl;
        x.pv  = pv;
        x.per = per;
        pq.push_back(x);
    endtask

    task automatic drive(input logic v, input int n);
        pm.signal = v;
        repeat (n) @(negedge clock);
    endtask

    // Reference synchronizer: counts rises the meter should see during the async phase.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m1 <= 1'b0;
            m2 <= 1'b0;
            m3 <= 1'b0;
        end else begin
            m1 <= pm.signal;
            m2 <= m1;
            m3 <= m2;
            if (async_mode && m2 && !m3) model_rises <= model_rises + 1;
        end
    end

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (pm.pulse_valid) begin
                last_pv_cyc <= cyc;
                if (async_mode) begin
                    check("async_high_len_nonzero", int'(pm.high_len != 0), 1);
                    async_pv <= async_pv + 1;
                end else if (pq.size() == 0) begin
                    check("unexpected_pulse_valid", int'(pm.pulse_valid), 0);
                end else begin
                    e = pq.pop_front();
                    check("high_len", int'(pm.high_len), e.hl);
                    check("period_valid", int'(pm.period_valid), int'(e.pv));
                    if (e.pv) check("period", int'(pm.period), e.per);
                end
            end else if (pm.period_valid) begin
                check("period_valid_without_pulse", int'(pm.period_valid), 0);
            end
            if (pm.burst_done) begin
                if (bq.size() == 0) begin
                    check("unexpected_burst_done", int'(pm.burst_done), 0);
                end else begin
                    b = bq.pop_front();
                    check("burst_count", int'(pm.burst_count), b);
                    check("burst_delay_after_last_pulse", cyc - last_pv_cyc, 15);
                end
            end
        end
    end

    task automatic check_drained(input string name);
        check({name, "_pending_pulses"}, pq.size(), 0);
        check({name, "_pending_bursts"}, bq.size(), 0);
    endtask

    initial begin
        pm.signal = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_high_len", int'(pm.high_len), 0);
        check("rst_period", int'(pm.period), 0);
        check("rst_burst_count", int'(pm.burst_count), 0);
        check("rst_overflow", int'(pm.overflow), 0);
        check("rst_strobes", int'({pm.pulse_valid, pm.period_valid, pm.burst_done}), 0);
        reset = 1'b0;
        drive(1'b0, 5);

        // Three 3-high/3-low pulses.
        push_pulse(3, 1'b0, 0);
        push_pulse(3, 1'b1, 6);
        push_pulse(3, 1'b1, 6);
        bq.push_back(3);
        repeat (3) begin
            drive(1'b1, 3);
            drive(1'b0, 3);
        end
        drive(1'b0, 30);
        check_drained("three_pulses");
        check("three_pulses_overflow", int'(pm.overflow), 0);

        // Single one-cycle pulse.
        push_pulse(1, 1'b0, 0);
        bq.push_back(1);
        drive(1'b1, 1);
        drive(1'b0, 30);
        check_drained("one_cycle");

        // Gap of TIMEOUT-1 keeps one burst.
        push_pulse(2, 1'b0, 0);
        push_pulse(2, 1'b1, 17);
        bq.push_back(2);
        drive(1'b1, 2);
        drive(1'b0, TIMEOUT - 1);
        drive(1'b1, 2);
        drive(1'b0, 30);
        check_drained("gap_short");

        // Gap of TIMEOUT splits into two bursts.
        push_pulse(2, 1'b0, 0);
        bq.push_back(1);
        push_pulse(2, 1'b0, 0);
        bq.push_back(1);
        drive(1'b1, 2);
        drive(1'b0, TIMEOUT);
        drive(1'b1, 2);
        drive(1'b0, 30);
        check_drained("gap_timeout");

        // Long high saturates the width counter.
        push_pulse(255, 1'b0, 0);
        bq.push_back(1);
        drive(1'b1, 300);
        drive(1'b0, 30);
        check_drained("stuck_high");
        check("stuck_high_overflow", int'(pm.overflow), 1);

        // Overflow holds until the next burst's first rise is taken.
        push_pulse(3, 1'b0, 0);
        bq.push_back(1);
        pm.signal = 1'b1;
        repeat (2) @(negedge clock);
        check("overflow_held_before_rise", int'(pm.overflow), 1);
        @(negedge clock);
        check("overflow_cleared_on_rise", int'(pm.overflow), 0);
        drive(1'b0, 30);
        check_drained("after_overflow");

        // Reset in the middle of a 5-cycle pulse.
        pm.signal = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_high_len", int'(pm.high_len), 0);
        check("midreset_period", int'(pm.period), 0);
        check("midreset_burst_count", int'(pm.burst_count), 0);
        check("midreset_overflow", int'(pm.overflow), 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        push_pulse(1, 1'b0, 0);
        bq.push_back(1);
        @(negedge clock);
        drive(1'b0, 30);
        check_drained("midreset");
        check("midreset_period_after", int'(pm.period), 0);

        // Asynchronous 8-unit toggling against the 12-unit clock half-period.
        async_mode = 1'b1;
        #3;
        repeat (16) begin
            pm.signal = ~pm.signal;
            #8;
        end
        pm.signal = 1'b0;
        repeat (5) @(negedge clock);
        bq.push_back(model_rises);
        drive(1'b0, 30);
        check("async_pulse_count", async_pv, model_rises);
        check("async_rise_count", model_rises, 2);
        async_mode = 1'b0;
        check_drained("async");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
